// File: rtl/lt100_bus_pkg.sv
// Shared types and constants for the lt100 two-master bus arbiter.
// Imported by the arbiter top and its watchdog.
package lt100_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic M_CPU = 1'b0;
   localparam logic M_AUX = 1'b1;

   localparam int DEF_TIMEOUT = 256;

endpackage

// File: rtl/lt100_bus_watchdog.sv
// Slave-access watchdog: counts while run=1, clears synchronously otherwise.
// expired is high in the cycle whose count equals limit-1; limit=0 disables it.
module lt100_bus_watchdog
   import lt100_bus_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [CNT_W-1:0] limit,
   output logic             expired
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (run) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   assign expired = run && (limit != '0) &&
                    (r_cnt == limit - CNT_W'(1));

endmodule

// File: rtl/lt100_bus_arb.sv
// Round-robin arbiter between the CPU and an auxiliary master in front of
// the single lt100 bus slave; all outputs are registered.
module lt100_bus_arb
   import lt100_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
   parameter int CNT_W          = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m0_enable,
   input  logic        m0_wr_en,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_i_data,
   input  logic [3:0]  m0_be,
   output logic        m0_ready,
   output logic [31:0] m0_o_data,
   output logic        m0_err,
   input  logic        m1_enable,
   input  logic        m1_wr_en,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_i_data,
   input  logic [3:0]  m1_be,
   output logic        m1_ready,
   output logic [31:0] m1_o_data,
   output logic        m1_err,
   output logic        s_enable,
   output logic        s_wr_en,
   output logic [31:0] s_addr,
   output logic [31:0] s_i_data,
   output logic [3:0]  s_be,
   input  logic        s_ready,
   input  logic [31:0] s_o_data,
   input  logic        s_err
);

   localparam logic [CNT_W-1:0] W_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_t      r_state;
   state_t      w_next;
   logic        r_last;
   logic        r_gnt;
   logic        w_gnt;
   logic        w_issue;
   logic        w_done;
   logic        w_abort;
   logic        w_expired;
   logic [31:0] w_rdata;
   logic        w_rerr;

   logic        r_s_enable;
   logic        r_s_wr_en;
   logic [31:0] r_s_addr;
   logic [31:0] r_s_i_data;
   logic [3:0]  r_s_be;
   logic        r_m0_ready;
   logic [31:0] r_m0_o_data;
   logic        r_m0_err;
   logic        r_m1_ready;
   logic [31:0] r_m1_o_data;
   logic        r_m1_err;

   lt100_bus_watchdog #(
      .CNT_W (CNT_W)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (r_state == ST_WAIT),
      .limit   (W_LIMIT),
      .expired (w_expired)
   );

   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      w_gnt = M_CPU;
      if (m0_enable && m1_enable) begin
         w_gnt = ~r_last;
      end else if (m1_enable) begin
         w_gnt = M_AUX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_enable || m1_enable) begin
               w_issue = 1'b1;
               w_next  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (s_ready) begin
               w_done = 1'b1;
               w_next = ST_GAP;
            end else if (w_expired) begin
               w_abort = 1'b1;
               w_next  = ST_GAP;
            end
         end
         ST_GAP:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_rdata = w_done ? s_o_data : 32'd0;
   assign w_rerr  = w_done ? s_err : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last      <= M_AUX;
         r_gnt       <= M_CPU;
         r_s_enable  <= 1'b0;
         r_s_wr_en   <= 1'b0;
         r_s_addr    <= '0;
         r_s_i_data  <= '0;
         r_s_be      <= '0;
         r_m0_ready  <= 1'b0;
         r_m0_o_data <= '0;
         r_m0_err    <= 1'b0;
         r_m1_ready  <= 1'b0;
         r_m1_o_data <= '0;
         r_m1_err    <= 1'b0;
      end else begin
         r_m0_ready <= 1'b0;
         r_m1_ready <= 1'b0;
         if (w_issue) begin
            r_gnt      <= w_gnt;
            r_s_enable <= 1'b1;
            r_s_wr_en  <= w_gnt ? m1_wr_en  : m0_wr_en;
            r_s_addr   <= w_gnt ? m1_addr   : m0_addr;
            r_s_i_data <= w_gnt ? m1_i_data : m0_i_data;
            r_s_be     <= w_gnt ? m1_be     : m0_be;
         end
         if (w_done || w_abort) begin
            r_s_enable <= 1'b0;
            if (r_gnt == M_AUX) begin
               r_m1_ready  <= 1'b1;
               r_m1_o_data <= w_rdata;
               r_m1_err    <= w_rerr;
            end else begin
               r_m0_ready  <= 1'b1;
               r_m0_o_data <= w_rdata;
               r_m0_err    <= w_rerr;
            end
         end
         if (w_done) begin
            r_last <= r_gnt;
         end
      end
   end

   assign s_enable  = r_s_enable;
   assign s_wr_en   = r_s_wr_en;
   assign s_addr    = r_s_addr;
   assign s_i_data  = r_s_i_data;
   assign s_be      = r_s_be;
   assign m0_ready  = r_m0_ready;
   assign m0_o_data = r_m0_o_data;
   assign m0_err    = r_m0_err;
   assign m1_ready  = r_m1_ready;
   assign m1_o_data = r_m1_o_data;
   assign m1_err    = r_m1_err;

endmodule

// File: tb/tb_lt100_bus_arb.sv
// Directed self-checking bench for lt100_bus_arb (watchdog limit 8).
// Each task drives one scenario and compares against hand-computed values.
module tb_lt100_bus_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_enable, m0_wr_en;
   logic [31:0] m0_addr, m0_i_data;
   logic [3:0]  m0_be;
   logic        m0_ready, m0_err;
   logic [31:0] m0_o_data;
   logic        m1_enable, m1_wr_en;
   logic [31:0] m1_addr, m1_i_data;
   logic [3:0]  m1_be;
   logic        m1_ready, m1_err;
   logic [31:0] m1_o_data;
   logic        s_enable, s_wr_en;
   logic [31:0] s_addr, s_i_data;
   logic [3:0]  s_be;
   logic        s_ready;
   logic [31:0] s_o_data;
   logic        s_err;

   logic        slv_auto;
   logic        slv_man;

   int n_checks = 0;
   int n_errors = 0;
   int n_m0 = 0;
   int n_m1 = 0;
   int n_rise = 0;
   logic        prev_en = 1'b0;
   logic [31:0] q_addr[$];

   always #5 clk = ~clk;

   lt100_bus_arb #(
      .TIMEOUT_CYCLES (8),
      .CNT_W          (9)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0_enable (m0_enable),
      .m0_wr_en  (m0_wr_en),
      .m0_addr   (m0_addr),
      .m0_i_data (m0_i_data),
      .m0_be     (m0_be),
      .m0_ready  (m0_ready),
      .m0_o_data (m0_o_data),
      .m0_err    (m0_err),
      .m1_enable (m1_enable),
      .m1_wr_en  (m1_wr_en),
      .m1_addr   (m1_addr),
      .m1_i_data (m1_i_data),
      .m1_be     (m1_be),
      .m1_ready  (m1_ready),
      .m1_o_data (m1_o_data),
      .m1_err    (m1_err),
      .s_enable  (s_enable),
      .s_wr_en   (s_wr_en),
      .s_addr    (s_addr),
      .s_i_data  (s_i_data),
      .s_be      (s_be),
      .s_ready   (s_ready),
      .s_o_data  (s_o_data),
      .s_err     (s_err)
   );

   // Ideal slave answers in the first WAIT cycle; manual mode for timeouts.
   always_comb begin
      s_ready = slv_auto ? s_enable : slv_man;
   end

   always @(negedge clk) begin
      if (m0_ready) n_m0 = n_m0 + 1;
      if (m1_ready) n_m1 = n_m1 + 1;
      if (s_enable && !prev_en) begin
         n_rise = n_rise + 1;
         q_addr.push_back(s_addr);
      end
      prev_en = s_enable;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      m0_enable = 1'b0; m0_wr_en = 1'b0; m0_addr = '0;
      m0_i_data = '0;   m0_be = '0;
      m1_enable = 1'b0; m1_wr_en = 1'b0; m1_addr = '0;
      m1_i_data = '0;   m1_be = '0;
      s_o_data  = '0;   s_err = 1'b0;
      slv_auto  = 1'b1; slv_man = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({s_enable, m0_ready, m1_ready, m0_err, m1_err} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_flags got %b want 00000",
                  {s_enable, m0_ready, m1_ready, m0_err, m1_err});
      end
      n_checks++;
      if ({s_addr, m0_o_data, m1_o_data} !== 96'd0) begin
         n_errors++;
         $display("FAIL reset_data got %h %h %h want 0", s_addr, m0_o_data, m1_o_data);
      end
   endtask

   task automatic test_read();
      int b0, b1;
      b0 = n_m0; b1 = n_m1;
      s_o_data = 32'hDEADBEEF; s_err = 1'b0;
      m0_enable = 1'b1; m0_wr_en = 1'b0; m0_addr = 32'h10; m0_be = 4'b1111;
      tick();
      n_checks++;
      if ({s_enable, s_wr_en, s_addr, s_be} !== {1'b1, 1'b0, 32'h10, 4'b1111}) begin
         n_errors++;
         $display("FAIL read_issue got en=%b wr=%b a=%h be=%b want 1 0 00000010 1111",
                  s_enable, s_wr_en, s_addr, s_be);
      end
      tick();
      n_checks++;
      if ({m0_ready, m0_o_data, m0_err, m1_ready} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL read_done got rdy=%b d=%h e=%b m1rdy=%b want 1 deadbeef 0 0",
                  m0_ready, m0_o_data, m0_err, m1_ready);
      end
      m0_enable = 1'b0;
      repeat (4) tick();
      n_checks++;
      if ((n_m0 - b0) != 1 || (n_m1 - b1) != 0) begin
         n_errors++;
         $display("FAIL read_pulses got m0=%0d m1=%0d want 1 0", n_m0 - b0, n_m1 - b1);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp;
      do_reset();
      q_addr.delete();
      s_o_data = 32'h11111111;
      m0_enable = 1'b1; m0_addr = 32'h100; m0_be = 4'hF;
      m1_enable = 1'b1; m1_addr = 32'h200; m1_be = 4'hF;
      for (int i = 0; i < 60 && q_addr.size() < 6; i++) tick();
      m0_enable = 1'b0; m1_enable = 1'b0;
      repeat (4) tick();
      n_checks++;
      if (q_addr.size() != 6) begin
         n_errors++;
         $display("FAIL rr_count got %0d grants want 6", q_addr.size());
      end
      for (int i = 0; i < 6 && i < q_addr.size(); i++) begin
         exp = (i % 2 == 0) ? 32'h100 : 32'h200;
         n_checks++;
         if (q_addr[i] !== exp) begin
            n_errors++;
            $display("FAIL rr_order[%0d] got %h want %h", i, q_addr[i], exp);
         end
      end
   endtask

   task automatic test_write_err();
      s_err = 1'b1;
      m1_enable = 1'b1; m1_wr_en = 1'b1; m1_addr = 32'h20000000;
      m1_i_data = 32'hA5; m1_be = 4'b0001;
      tick();
      n_checks++;
      if ({s_enable, s_wr_en, s_i_data, s_be, s_addr} !==
          {1'b1, 1'b1, 32'hA5, 4'b0001, 32'h20000000}) begin
         n_errors++;
         $display("FAIL wr_issue got en=%b wr=%b d=%h be=%b a=%h want 1 1 a5 0001 20000000",
                  s_enable, s_wr_en, s_i_data, s_be, s_addr);
      end
      tick();
      n_checks++;
      if ({m1_ready, m1_err, m0_ready, m0_err} !== 4'b1100) begin
         n_errors++;
         $display("FAIL wr_err got m1rdy=%b m1err=%b m0rdy=%b m0err=%b want 1 1 0 0",
                  m1_ready, m1_err, m0_ready, m0_err);
      end
      m1_enable = 1'b0; m1_wr_en = 1'b0; s_err = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      int b0, b1;
      slv_auto = 1'b0; slv_man = 1'b0;
      m0_enable = 1'b1; m0_wr_en = 1'b0; m0_addr = 32'h30; m0_be = 4'hF;
      tick();
      repeat (7) tick();
      n_checks++;
      if ({s_enable, m0_ready} !== 2'b10) begin
         n_errors++;
         $display("FAIL to_hold got en=%b rdy=%b want 1 0", s_enable, m0_ready);
      end
      tick();
      n_checks++;
      if ({s_enable, m0_ready, m0_err, m0_o_data} !== {3'b011, 32'd0}) begin
         n_errors++;
         $display("FAIL to_abort got en=%b rdy=%b e=%b d=%h want 0 1 1 0",
                  s_enable, m0_ready, m0_err, m0_o_data);
      end
      m0_enable = 1'b0;
      tick();
      b0 = n_m0; b1 = n_m1;
      slv_man = 1'b1;
      repeat (3) tick();
      slv_man = 1'b0;
      tick();
      n_checks++;
      if ((n_m0 - b0) != 0 || (n_m1 - b1) != 0 || s_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL to_late got m0=%0d m1=%0d en=%b want 0 0 0",
                  n_m0 - b0, n_m1 - b1, s_enable);
      end
      slv_auto = 1'b1; s_o_data = 32'h12345678;
      m0_enable = 1'b1; m0_addr = 32'h40;
      tick(); tick();
      n_checks++;
      if ({m0_ready, m0_err, m0_o_data} !== {2'b10, 32'h12345678}) begin
         n_errors++;
         $display("FAIL to_next got rdy=%b e=%b d=%h want 1 0 12345678",
                  m0_ready, m0_err, m0_o_data);
      end
      m0_enable = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      int b0, b1;
      slv_auto = 1'b0; slv_man = 1'b0;
      m0_enable = 1'b1; m0_addr = 32'h50;
      tick();
      m1_enable = 1'b1; m1_wr_en = 1'b0; m1_addr = 32'h60; m1_be = 4'hF;
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({s_enable, m0_ready, m1_ready} !== 3'b000) begin
         n_errors++;
         $display("FAIL rstmid_drop got en=%b r0=%b r1=%b want 0 0 0",
                  s_enable, m0_ready, m1_ready);
      end
      m0_enable = 1'b0;
      b0 = n_m0; b1 = n_m1;
      q_addr.delete();
      tick(); tick();
      rst_n = 1'b1;
      slv_auto = 1'b1; s_o_data = 32'hCAFE0001;
      tick(); tick();
      n_checks++;
      if ({m1_ready, m1_o_data} !== {1'b1, 32'hCAFE0001}) begin
         n_errors++;
         $display("FAIL rstmid_m1 got rdy=%b d=%h want 1 cafe0001", m1_ready, m1_o_data);
      end
      m1_enable = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (q_addr.size() != 1 || (q_addr.size() == 1 && q_addr[0] !== 32'h60)) begin
         n_errors++;
         $display("FAIL rstmid_grant got n=%0d want one grant to 00000060", q_addr.size());
      end
      n_checks++;
      if ((n_m0 - b0) != 0 || (n_m1 - b1) != 1) begin
         n_errors++;
         $display("FAIL rstmid_pulses got m0=%0d m1=%0d want 0 1", n_m0 - b0, n_m1 - b1);
      end
   endtask

   task automatic test_back_to_back();
      int br, b0;
      br = n_rise; b0 = n_m0;
      slv_auto = 1'b1; s_o_data = 32'h0000BEEF;
      m0_enable = 1'b1; m0_addr = 32'h70;
      tick(); tick();
      n_checks++;
      if (m0_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_ready got %b want 1", m0_ready);
      end
      tick();
      m0_enable = 1'b0;
      repeat (4) tick();
      n_checks++;
      if ((n_rise - br) != 1 || (n_m0 - b0) != 1 || s_enable !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_single got rises=%0d pulses=%0d en=%b want 1 1 0",
                  n_rise - br, n_m0 - b0, s_enable);
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_round_robin();
      test_write_err();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
